vc_re_fifo: RTL and testbench

Multi-virtual-channel router input buffer: the parametrised successor of the single-channel router-input FIFO. It holds NVC independent circular queues of DEPTH flits each behind one shared write port and one shared read port. Per-VC it reports empty, full and "room for one whole packet" (ordy). It returns a registered credit to the upstream router for every flit popped. It sits at each router input port, between the link receiver and the VC allocator / switch arbiter.

---
 rtl/vc_re_fifo_pkg.sv | 15 +
 rtl/vc_ring.sv | 56 +++++
 rtl/vc_re_fifo.sv | 98 +++++++++
 tb/tb_vc_re_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vc_re_fifo_pkg.sv
// rtl/vc_re_fifo_pkg.sv - shared defaults and width helpers for the multi-VC router input buffer
package vc_re_fifo_pkg;

  // Router, link and credit counters all take their defaults from here
  localparam int DEF_DATAW     = 32;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_NVC       = 2;
  localparam int DEF_PKT_FLITS = 1;

  // Index width for n entries, never below one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vc_ring.sv
// rtl/vc_ring.sv - single-VC circular flit buffer with pointers, occupancy and free count
module vc_ring
  import vc_re_fifo_pkg::*;
#(
  parameter  int DATAW = DEF_DATAW,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PTRW  = idx_width(DEPTH),
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [DATAW:0]  wdata,
  input  logic            push,
  input  logic            pop,
  output logic [DATAW:0]  head,
  output logic            empty,
  output logic            full,
  output logic [CNTW-1:0] free_cnt
);

  logic [DATAW:0]  ram [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [CNTW-1:0] cnt;

  // Explicit wrap so DEPTH need not be a power of two
  function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else begin
      if (push) begin
        ram[wr_ptr] <= wdata;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head     = ram[rd_ptr];
  assign empty    = (cnt == '0);
  assign full     = (cnt == CNTW'(DEPTH));
  assign free_cnt = CNTW'(DEPTH) - cnt;

endmodule

// File: rtl/vc_re_fifo.sv
// rtl/vc_re_fifo.sv - multi-VC router input buffer: shared write/read ports, per-VC status, credit return
module vc_re_fifo
  import vc_re_fifo_pkg::*;
#(
  parameter  int DATAW     = DEF_DATAW,
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int NVC       = DEF_NVC,
  parameter  int PKT_FLITS = DEF_PKT_FLITS,
  localparam int VCW       = idx_width(NVC)
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic [DATAW:0] idata,
  input  logic           wr_en,
  input  logic [VCW-1:0] wr_vc,
  input  logic           rd_en,
  input  logic [VCW-1:0] rd_vc,
  output logic [DATAW:0] odata,
  output logic [NVC-1:0] empty,
  output logic [NVC-1:0] full,
  output logic [NVC-1:0] ordy,
  output logic           credit,
  output logic [VCW-1:0] credit_vc,
  output logic           ovf
);

  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DATAW:0]  head_v [NVC];
  logic [CNTW-1:0] free_v [NVC];
  logic [NVC-1:0]  push_v;
  logic [NVC-1:0]  pop_v;

  logic           wr_hit;
  logic           wr_full;
  logic           rd_empty;
  logic [DATAW:0] rd_head;
  logic           pop;
  logic           push;
  logic           drop;

  // Out-of-range VC indices never match, so they read as empty and write as a drop
  always_comb begin
    wr_hit   = 1'b0;
    wr_full  = 1'b0;
    rd_empty = 1'b1;
    rd_head  = '0;
    for (int v = 0; v < NVC; v++) begin
      if (wr_vc == VCW'(v)) begin
        wr_hit  = 1'b1;
        wr_full = full[v];
      end
      if (rd_vc == VCW'(v)) begin
        rd_empty = empty[v];
        rd_head  = head_v[v];
      end
    end
  end

  assign pop   = rd_en & ~rd_empty;
  assign push  = wr_en & wr_hit & (~wr_full | (pop & (rd_vc == wr_vc)));
  assign drop  = wr_en & ~push;
  assign odata = rd_empty ? '0 : rd_head;

  for (genvar v = 0; v < NVC; v++) begin : g_vc
    assign push_v[v] = push & (wr_vc == VCW'(v));
    assign pop_v[v]  = pop & (rd_vc == VCW'(v));
    assign ordy[v]   = (free_v[v] >= CNTW'(PKT_FLITS));

    vc_ring #(
      .DATAW (DATAW),
      .DEPTH (DEPTH)
    ) u_ring (
      .clk      (clk),
      .rst_     (rst_),
      .wdata    (idata),
      .push     (push_v[v]),
      .pop      (pop_v[v]),
      .head     (head_v[v]),
      .empty    (empty[v]),
      .full     (full[v]),
      .free_cnt (free_v[v])
    );
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      credit    <= 1'b0;
      credit_vc <= '0;
      ovf       <= 1'b0;
    end else begin
      credit <= pop;
      if (pop) credit_vc <= rd_vc;
      if (drop) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_re_fifo.sv
// tb/tb_vc_re_fifo.sv - directed self-checking bench for vc_re_fifo (DEPTH=4, NVC=2)
module tb_vc_re_fifo;

  logic        clk = 1'b0;
  logic        rst_;
  logic [32:0] idata;
  logic        wr_en;
  logic [0:0]  wr_vc;
  logic        rd_en;
  logic [0:0]  rd_vc;

  logic [32:0] odata,  odata3;
  logic [1:0]  empty,  empty3;
  logic [1:0]  full,   full3;
  logic [1:0]  ordy,   ordy3;
  logic        credit, credit3;
  logic [0:0]  credit_vc, credit_vc3;
  logic        ovf,    ovf3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vc_re_fifo #(.DATAW(32), .DEPTH(4), .NVC(2), .PKT_FLITS(1)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .wr_en(wr_en), .wr_vc(wr_vc),
    .rd_en(rd_en), .rd_vc(rd_vc), .odata(odata), .empty(empty), .full(full),
    .ordy(ordy), .credit(credit), .credit_vc(credit_vc), .ovf(ovf)
  );

  vc_re_fifo #(.DATAW(32), .DEPTH(4), .NVC(2), .PKT_FLITS(3)) dut3 (
    .clk(clk), .rst_(rst_), .idata(idata), .wr_en(wr_en), .wr_vc(wr_vc),
    .rd_en(rd_en), .rd_vc(rd_vc), .odata(odata3), .empty(empty3), .full(full3),
    .ordy(ordy3), .credit(credit3), .credit_vc(credit_vc3), .ovf(ovf3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [0:0] vc, input logic [32:0] d);
    wr_en = 1'b1;
    wr_vc = vc;
    idata = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Check head before the edge, then the credit pulse after it
  task automatic pop_chk(input string tag, input logic [0:0] vc, input logic [32:0] exp);
    rd_vc = vc;
    rd_en = 1'b1;
    #1;
    check({tag, "_odata"}, 64'(odata), 64'(exp));
    tick();
    rd_en = 1'b0;
    check({tag, "_credit"}, 64'(credit), 64'd1);
    check({tag, "_credit_vc"}, 64'(credit_vc), 64'(vc));
  endtask

  initial begin
    rst_  = 1'b0;
    idata = '0;
    wr_en = 1'b0;
    wr_vc = '0;
    rd_en = 1'b0;
    rd_vc = '0;
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b1;
    #1;
    check("rst_empty",  64'(empty),  64'h3);
    check("rst_full",   64'(full),   64'h0);
    check("rst_ordy",   64'(ordy),   64'h3);
    check("rst_odata",  64'(odata),  64'h0);
    check("rst_credit", 64'(credit), 64'h0);
    check("rst_ovf",    64'(ovf),    64'h0);

    // Reset mid-operation discards stored flits
    wr(1'b0, 33'h11);
    wr(1'b0, 33'h12);
    wr(1'b0, 33'h13);
    rd_vc = 1'b0;
    #1;
    check("pre_rst_empty", 64'(empty), 64'h2);
    check("pre_rst_odata", 64'(odata), 64'h11);
    #1 rst_ = 1'b0;
    #1;
    check("mid_rst_empty", 64'(empty), 64'h3);
    check("mid_rst_odata", 64'(odata), 64'h0);
    check("mid_rst_ovf",   64'(ovf),   64'h0);
    tick();
    rst_ = 1'b1;
    tick();
    check("post_rst_credit", 64'(credit), 64'h0);
    check("post_rst_empty",  64'(empty),  64'h3);

    // Fill and wrap on VC1
    wr(1'b1, 33'h1);
    wr(1'b1, 33'h2);
    wr(1'b1, 33'h3);
    wr(1'b1, 33'h4);
    check("fill_full", 64'(full), 64'h2);
    check("fill_ordy", 64'(ordy), 64'h1);
    pop_chk("wrap_p1", 1'b1, 33'h1);
    check("wrap_full_clr", 64'(full), 64'h0);
    pop_chk("wrap_p2", 1'b1, 33'h2);
    wr(1'b1, 33'h5);
    wr(1'b1, 33'h6);
    check("wrap_refull", 64'(full), 64'h2);
    pop_chk("wrap_p3", 1'b1, 33'h3);
    pop_chk("wrap_p4", 1'b1, 33'h4);
    pop_chk("wrap_p5", 1'b1, 33'h5);
    pop_chk("wrap_p6", 1'b1, 33'h6);
    check("wrap_empty", 64'(empty), 64'h3);
    tick();
    check("wrap_credit_end", 64'(credit), 64'h0);

    // Full VC0 with simultaneous write and pop
    wr(1'b0, 33'h21);
    wr(1'b0, 33'h22);
    wr(1'b0, 33'h23);
    wr(1'b0, 33'h24);
    check("sim_full_pre", 64'(full), 64'h1);
    wr_en = 1'b1;
    wr_vc = 1'b0;
    idata = 33'hA;
    rd_en = 1'b1;
    rd_vc = 1'b0;
    #1;
    check("sim_odata", 64'(odata), 64'h21);
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("sim_full_post", 64'(full),   64'h1);
    check("sim_ovf",       64'(ovf),    64'h0);
    check("sim_credit",    64'(credit), 64'h1);
    pop_chk("sim_p1", 1'b0, 33'h22);
    pop_chk("sim_p2", 1'b0, 33'h23);
    pop_chk("sim_p3", 1'b0, 33'h24);
    pop_chk("sim_p4", 1'b0, 33'hA);
    check("sim_empty", 64'(empty), 64'h3);

    // Overflow on full VC0 is sticky
    wr(1'b0, 33'h31);
    wr(1'b0, 33'h32);
    wr(1'b0, 33'h33);
    wr(1'b0, 33'h34);
    wr(1'b0, 33'h99);
    check("ovf_set",  64'(ovf),  64'h1);
    check("ovf_full", 64'(full), 64'h1);
    repeat (20) tick();
    check("ovf_hold", 64'(ovf), 64'h1);
    pop_chk("ovf_p1", 1'b0, 33'h31);
    pop_chk("ovf_p2", 1'b0, 33'h32);
    pop_chk("ovf_p3", 1'b0, 33'h33);
    pop_chk("ovf_p4", 1'b0, 33'h34);
    check("ovf_empty", 64'(empty), 64'h3);
    check("ovf_still", 64'(ovf),   64'h1);

    // Isolation: write VC0 while popping VC1
    wr(1'b1, 33'h41);
    wr(1'b1, 33'h42);
    wr(1'b1, 33'h43);
    wr(1'b1, 33'h44);
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_vc = 1'b0;
      idata = 33'(32'h51 + i);
      rd_en = 1'b1;
      rd_vc = 1'b1;
      #1;
      check("iso_vc1_head", 64'(odata), 64'(32'h41 + i));
      tick();
      check("iso_credit_vc", 64'(credit_vc), 64'h1);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("iso_empty_pop_credit", 64'(credit), 64'h0);
    end
    rd_en = 1'b0;
    rd_vc = 1'b0;
    #1;
    check("iso_full",     64'(full),  64'h1);
    check("iso_empty",    64'(empty), 64'h2);
    check("iso_vc0_head", 64'(odata), 64'h51);
    pop_chk("iso_p1", 1'b0, 33'h51);
    pop_chk("iso_p2", 1'b0, 33'h52);
    pop_chk("iso_p3", 1'b0, 33'h53);
    pop_chk("iso_p4", 1'b0, 33'h54);

    // ordy threshold with PKT_FLITS=3 on dut3, PKT_FLITS=1 on dut
    check("ordy3_c0", 64'(ordy3[0]), 64'h1);
    wr(1'b0, 33'h61);
    check("ordy3_c1", 64'(ordy3[0]), 64'h1);
    wr(1'b0, 33'h62);
    check("ordy3_c2", 64'(ordy3[0]), 64'h0);
    wr(1'b0, 33'h63);
    check("ordy3_c3", 64'(ordy3[0]), 64'h0);
    check("ordy1_c3", 64'(ordy[0]),  64'h1);
    wr(1'b0, 33'h64);
    check("ordy3_c4", 64'(ordy3[0]), 64'h0);
    check("ordy1_c4", 64'(ordy[0]),  64'h0);
    pop_chk("ord_p1", 1'b0, 33'h61);
    pop_chk("ord_p2", 1'b0, 33'h62);
    pop_chk("ord_p3", 1'b0, 33'h63);
    check("ordy3_back1", 64'(ordy3[0]), 64'h1);
    pop_chk("ord_p4", 1'b0, 33'h64);
    rd_en = 1'b1;
    rd_vc = 1'b0;
    #1;
    check("empty_pop_odata", 64'(odata), 64'h0);
    tick();
    rd_en = 1'b0;
    check("empty_pop_credit", 64'(credit), 64'h0);
    check("empty_pop_empty",  64'(empty),  64'h3);
    check("dut3_odata_match", 64'(odata3), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
